// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI responder: register map, status bits, FSM states.
package spi_slave_pkg;

    localparam logic [2:0] A_DATA = 3'd0;
    localparam logic [2:0] A_STAT = 3'd1;
    localparam logic [2:0] A_FILL = 3'd2;
    localparam logic [2:0] A_SRST = 3'd7;

    localparam int S_RXF = 0;
    localparam int S_TXE = 1;
    localparam int S_OVR = 2;
    localparam int S_BSY = 3;
    localparam int S_IEN = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT
    } state_t;

endpackage

// File: rtl/spi_slave_sync.sv
// Synchronizer chain for an asynchronous SPI pin with rise/fall pulses.
module spi_slave_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_chain;
    logic              r_prev;
    logic              w_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_chain <= {STAGES{RST_VAL}};
            r_prev  <= RST_VAL;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
            r_prev  <= r_chain[STAGES-1];
        end
    end

    assign w_q    = r_chain[STAGES-1];
    assign o_rise = w_q & ~r_prev;
    assign o_fall = ~w_q & r_prev;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder, 8-bit MSB-first frames, CPU register interface.
// Optional irq output enabled by defining SPI_SLAVE_IRQ_EN.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL_RESET  = 8'hFF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       rnw,
    input  logic [2:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       ss,
    output logic       miso,
    output logic       miso_oe
`ifdef SPI_SLAVE_IRQ_EN
    ,
    output logic       irq
`endif
);

    state_t r_state, w_next;

    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [7:0] r_dout, r_fill, r_tx_buf, r_rx_data;
    logic [6:0] r_shreg_tx, r_shreg_rx;
    logic [3:0] r_bitcnt;
    logic       r_miso, r_miso_oe;
    logic       r_rx_full, r_tx_empty, r_overrun;
    logic       r_irq_en;

    logic w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;
    logic w_mosi, w_rd, w_wr, w_soft, w_rd_data, w_wr_data;
    logic w_rx_done, w_busy;
    logic [7:0] w_rx_byte, w_tx_byte, w_status, w_rd_mux;

    spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .reset_n(reset_n), .i_d(sclk),
        .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
        .clk(clk), .reset_n(reset_n), .i_d(ss),
        .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_mosi_sync <= '0;
        else          r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
    end

    assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
    assign w_rd      = enable & rnw;
    assign w_wr      = enable & ~rnw;
    assign w_soft    = w_wr & (addr == A_SRST);
    assign w_rd_data = w_rd & (addr == A_DATA);
    assign w_wr_data = w_wr & (addr == A_DATA);
    assign w_rx_byte = {r_shreg_rx, w_mosi};
    assign w_tx_byte = r_tx_empty ? r_fill : r_tx_buf;
    assign w_busy    = (r_state != ST_IDLE);
    assign w_rx_done = (r_state == ST_SHIFT) & w_sclk_rise
                     & (r_bitcnt == 4'd7);

`ifdef SPI_SLAVE_IRQ_EN
    assign w_status = {3'b0, r_irq_en, w_busy, r_overrun, r_tx_empty, r_rx_full};
`else
    assign w_status = {3'b0, 1'b0, w_busy, r_overrun, r_tx_empty, r_rx_full};
`endif

    always_comb begin
        w_rd_mux = '0;
        case (addr)
            A_DATA:  w_rd_mux = r_rx_data;
            A_STAT:  w_rd_mux = w_status;
            default: w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_ss_fall) w_next = ST_LOAD;
            ST_LOAD:  w_next = ST_SHIFT;
            ST_SHIFT: if (w_sclk_fall && r_bitcnt == 4'd8) w_next = ST_LOAD;
            default:  w_next = ST_IDLE;
        endcase
        if (w_ss_rise || w_soft) w_next = ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dout     <= '0;
            r_miso     <= 1'b1;
            r_miso_oe  <= 1'b0;
            r_rx_full  <= 1'b0;
            r_tx_empty <= 1'b1;
            r_overrun  <= 1'b0;
            r_fill     <= FILL_RESET;
            r_tx_buf   <= '0;
            r_rx_data  <= '0;
            r_shreg_tx <= '0;
            r_shreg_rx <= '0;
            r_bitcnt   <= '0;
            r_irq_en   <= 1'b0;
        end else if (w_soft) begin
            // Soft reset keeps the fill byte so the host can preconfigure it
            r_dout     <= '0;
            r_miso     <= 1'b1;
            r_miso_oe  <= 1'b0;
            r_rx_full  <= 1'b0;
            r_tx_empty <= 1'b1;
            r_overrun  <= 1'b0;
            r_tx_buf   <= '0;
            r_rx_data  <= '0;
            r_shreg_tx <= '0;
            r_shreg_rx <= '0;
            r_bitcnt   <= '0;
            r_irq_en   <= 1'b0;
        end else begin
            if (w_rd) r_dout <= w_rd_mux;
            if (w_rd_data) r_rx_full <= 1'b0;
            if (w_wr && addr == A_STAT) begin
                r_overrun <= 1'b0;
`ifdef SPI_SLAVE_IRQ_EN
                r_irq_en  <= din[S_IEN];
`endif
            end
            if (w_wr && addr == A_FILL) r_fill <= din;
            case (r_state)
                ST_LOAD: begin
                    r_shreg_tx <= w_tx_byte[6:0];
                    r_miso     <= w_tx_byte[7];
                    r_tx_empty <= 1'b1;
                    r_miso_oe  <= 1'b1;
                    r_bitcnt   <= '0;
                end
                ST_SHIFT: begin
                    if (w_sclk_rise && r_bitcnt != 4'd8) begin
                        r_shreg_rx <= w_rx_byte[6:0];
                        r_bitcnt   <= r_bitcnt + 4'd1;
                    end
                    // A completing byte wins over a same-cycle read clear
                    if (w_rx_done) begin
                        if (r_rx_full && !w_rd_data) begin
                            r_overrun <= 1'b1;
                        end else begin
                            r_rx_data <= w_rx_byte;
                            r_rx_full <= 1'b1;
                        end
                    end
                    if (w_sclk_fall && r_bitcnt != 4'd8) begin
                        r_miso     <= r_shreg_tx[6];
                        r_shreg_tx <= {r_shreg_tx[5:0], 1'b0};
                    end
                end
                default: ;
            endcase
            if (w_wr_data) begin
                r_tx_buf   <= din;
                r_tx_empty <= 1'b0;
            end
            if (w_ss_rise) r_miso_oe <= 1'b0;
        end
    end

`ifdef SPI_SLAVE_IRQ_EN
    logic r_irq;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_irq <= 1'b0;
        else          r_irq <= r_irq_en & (r_rx_full | r_overrun);
    end
    assign irq = r_irq;
`endif

    assign dout    = r_dout;
    assign miso    = r_miso;
    assign miso_oe = r_miso_oe;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: host register accesses plus a bit-banged SPI master.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       rnw = 1'b0;
    logic [2:0] addr = '0;
    logic [7:0] din = '0;
    logic [7:0] dout;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       ss = 1'b1;
    logic       miso;
    logic       miso_oe;
`ifdef SPI_SLAVE_IRQ_EN
    logic       irq;
`endif

    int n_pass = 0;
    int n_total = 0;

    spi_slave dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .rnw(rnw),
        .addr(addr), .din(din), .dout(dout),
        .sclk(sclk), .mosi(mosi), .ss(ss),
        .miso(miso), .miso_oe(miso_oe)
`ifdef SPI_SLAVE_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        enable = 1'b1; rnw = 1'b0; addr = a; din = d;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic cpu_rd(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        enable = 1'b1; rnw = 1'b1; addr = a;
        @(negedge clk);
        enable = 1'b0;
        d = dout;
    endtask

    task automatic ss_low();
        @(negedge clk);
        ss = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic ss_high();
        @(negedge clk);
        ss = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Mode 0 master at clk/8: MISO sampled as SCLK rises
    task automatic spi_bits(input logic [7:0] tx, input int n,
                            output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - n; i--) begin
            @(negedge clk);
            mosi = tx[i];
            repeat (3) @(negedge clk);
            rx[i] = miso;
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] tx, output logic [7:0] rx);
        ss_low();
        spi_bits(tx, 8, rx);
        ss_high();
    endtask

    logic [7:0] r, r2, d;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_dout", dout, 8'h00);
        chk("rst_oe", {7'b0, miso_oe}, 8'h00);
        chk("rst_miso", {7'b0, miso}, 8'h01);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        cpu_rd(3'd1, d);
        chk("rst_status", d, 8'h02);

        ss_low();
        spi_bits(8'hF0, 3, r);
        chk("mid_oe", {7'b0, miso_oe}, 8'h01);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_oe", {7'b0, miso_oe}, 8'h00);
        chk("mid_rst_dout", dout, 8'h00);
        ss = 1'b1;
        sclk = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        cpu_rd(3'd1, d);
        chk("mid_status", d, 8'h02);

        cpu_wr(3'd0, 8'hA5);
        frame(8'h3C, r);
        chk("t2_miso", r, 8'hA5);
        cpu_rd(3'd1, d);
        chk("t2_status", d, 8'h03);
        cpu_rd(3'd0, d);
        chk("t2_rx", d, 8'h3C);
        cpu_rd(3'd1, d);
        chk("t2_status_clr", d, 8'h02);

        cpu_wr(3'd2, 8'h00);
        frame(8'h55, r);
        chk("t3_fill", r, 8'h00);
        cpu_rd(3'd0, d);
        chk("t3_rx", d, 8'h55);

        frame(8'h11, r);
        frame(8'h22, r);
        cpu_rd(3'd1, d);
        chk("t4_status", d, 8'h07);
        cpu_rd(3'd0, d);
        chk("t4_rx", d, 8'h11);
        cpu_wr(3'd1, 8'h00);
        cpu_rd(3'd1, d);
        chk("t4_ovr_clr", d, 8'h02);

        ss_low();
        spi_bits(8'h99, 5, r);
        ss_high();
        cpu_rd(3'd1, d);
        chk("t5_status", d, 8'h02);
        frame(8'h7E, r);
        cpu_rd(3'd0, d);
        chk("t5_rx", d, 8'h7E);

        cpu_wr(3'd0, 8'hC3);
        ss_low();
        cpu_wr(3'd0, 8'h5A);
        spi_bits(8'h81, 8, r);
        cpu_rd(3'd0, d);
        chk("t6_rx1", d, 8'h81);
        repeat (6) @(negedge clk);
        spi_bits(8'h42, 8, r2);
        ss_high();
        chk("t6_miso1", r, 8'hC3);
        chk("t6_miso2", r2, 8'h5A);
        cpu_rd(3'd0, d);
        chk("t6_rx2", d, 8'h42);

        cpu_wr(3'd2, 8'h33);
        cpu_wr(3'd0, 8'h99);
        cpu_rd(3'd1, d);
        chk("srst_pre", d, 8'h00);
        cpu_wr(3'd7, 8'h00);
        cpu_rd(3'd1, d);
        chk("srst_status", d, 8'h02);
        frame(8'h00, r);
        chk("srst_fill_kept", r, 8'h33);

        cpu_wr(3'd5, 8'hFF);
        cpu_rd(3'd5, d);
        chk("unused_addr", d, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
